program_loader: RTL and testbench

- Host-side front end of the instruction-memory program-load protocol.
- Consumes a raw byte stream from the UART receiver (length header followed by payload).
- Drives the fetch-stage loader interface: input_start, input_data, input_valid, input_end.
- Guarantees the protocol ordering the fetch stage expects: one start pulse, N*4 single-cycle byte strobes, one end pulse. Also reports bad headers and stalled transfers.

---
 rtl/program_loader.sv | 218 +++++++++++++++++++++
 tb/tb_program_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: host-side front end of the instruction-memory program load.
// Parses a big-endian 32-bit word-count header from the UART byte stream, then
// forwards count*4 payload bytes to the fetch-stage loader, framed by a single
// start pulse and a single end pulse. Bad headers and stalled transfers are
// reported through the sticky error flag.
//
// Ports:
//   CLK          system clock, rising edge
//   reset        asynchronous, active-high reset
//   loader_go    arm pulse, honoured only in IDLE/DONE/ERR
//   rx_data      byte from the UART receiver
//   rx_valid     one-cycle strobe qualifying rx_data
//   input_data   payload byte to the fetch stage (holds between strobes)
//   input_valid  one-cycle strobe for input_data
//   input_start  one-cycle program-load start pulse
//   input_end    one-cycle program-load end pulse
//   busy         high while a load is in progress (HDR/START/DATA/END)
//   done         high in DONE, sticky until the next arm
//   error        high in ERR, sticky until the next arm
//
// State table:
//   state   | meaning
//   IDLE    | waiting for loader_go after reset
//   HDR     | collecting the 4 header bytes (word count, MSB first)
//   START   | input_start high; a byte arriving now is the first payload byte
//   DATA    | forwarding payload bytes with one cycle of latency
//   END     | input_end high; goes to DONE, or ERR after a payload timeout
//   DONE    | load completed
//   ERR     | header too large or rx stream stalled
module program_loader #(
  parameter int INST_MEM_WIDTH = 14,
  parameter int TIMEOUT        = 1000000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       loader_go,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] input_data,
  output logic       input_valid,
  output logic       input_start,
  output logic       input_end,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int BCNT_W = INST_MEM_WIDTH + 3;
  localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] MAX_WORDS = 32'(1) << INST_MEM_WIDTH;
  // The timeout decision is taken one cycle early so that the registered
  // consequence (ERR, or the abort end pulse) lands exactly TIMEOUT cycles
  // after the last rx byte.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_START,
    S_DATA,
    S_END,
    S_DONE,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        count_q, count_d;
  logic [1:0]         hdr_cnt_q, hdr_cnt_d;
  logic [BCNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0]  idle_q, idle_d;
  logic               abort_q, abort_d;
  logic [7:0]         input_data_q, input_data_d;
  logic               input_valid_q, input_valid_d;
  logic               input_start_q, input_start_d;
  logic               input_end_q, input_end_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  // count never exceeds 2**INST_MEM_WIDTH once START is reached, so the
  // byte total fits the INST_MEM_WIDTH+3 bit byte counter.
  logic [BCNT_W-1:0]  total_bytes;
  assign total_bytes = {count_q[INST_MEM_WIDTH:0], 2'b00};

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    hdr_cnt_d     = hdr_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    idle_d        = '0;
    abort_d       = abort_q;
    input_data_d  = input_data_q;
    input_valid_d = 1'b0;
    input_start_d = 1'b0;
    input_end_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (loader_go) begin
          state_d    = S_HDR;
          count_d    = '0;
          hdr_cnt_d  = '0;
          byte_cnt_d = '0;
          abort_d    = 1'b0;
        end
      end

      S_HDR: begin
        if (rx_valid) begin
          count_d   = {count_q[23:0], rx_data};
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) begin
            if (count_d > MAX_WORDS) begin
              state_d = S_ERR;
            end else begin
              state_d       = S_START;
              input_start_d = 1'b1;
            end
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d = S_ERR;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      S_START: begin
        // A byte landing here is captured straight into the output register,
        // which serves as the one-entry skid and emits it in the first DATA
        // cycle.
        if (count_q == 32'd0) begin
          state_d     = S_END;
          input_end_d = 1'b1;
        end else begin
          state_d = S_DATA;
          if (rx_valid) begin
            input_data_d  = rx_data;
            input_valid_d = 1'b1;
            byte_cnt_d    = byte_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        // Once the last byte is in flight, further rx bytes are discarded.
        if (byte_cnt_q == total_bytes) begin
          state_d     = S_END;
          input_end_d = 1'b1;
        end else if (rx_valid) begin
          input_data_d  = rx_data;
          input_valid_d = 1'b1;
          byte_cnt_d    = byte_cnt_q + 1'b1;
        end else if (idle_q == IDLE_LAST) begin
          // Close the frame so the fetch stage is released, then report ERR.
          state_d     = S_END;
          input_end_d = 1'b1;
          abort_d     = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      S_END: begin
        state_d = abort_q ? S_ERR : S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d == S_HDR) || (state_d == S_START) ||
              (state_d == S_DATA) || (state_d == S_END);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERR);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      hdr_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      idle_q        <= '0;
      abort_q       <= 1'b0;
      input_data_q  <= '0;
      input_valid_q <= 1'b0;
      input_start_q <= 1'b0;
      input_end_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      hdr_cnt_q     <= hdr_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      idle_q        <= idle_d;
      abort_q       <= abort_d;
      input_data_q  <= input_data_d;
      input_valid_q <= input_valid_d;
      input_start_q <= input_start_d;
      input_end_q   <= input_end_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign input_data  = input_data_q;
  assign input_valid = input_valid_q;
  assign input_start = input_start_q;
  assign input_end   = input_end_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader with INST_MEM_WIDTH=2 and TIMEOUT=16.
// Stimulus is a per-cycle plan (arm pulse at offset 0, rx bytes at chosen
// offsets); a cycle-arithmetic reference model turns the plan into the list of
// output strobes and the final done/error state, which are compared with what
// a monitor recorded from the DUT.
module tb_program_loader;

  localparam int W = 2;
  localparam int T = 16;

  logic       CLK       = 1'b0;
  logic       reset     = 1'b1;
  logic       loader_go = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       rx_valid  = 1'b0;
  logic [7:0] input_data;
  logic       input_valid, input_start, input_end, busy, done, error;

  program_loader #(.INST_MEM_WIDTH(W), .TIMEOUT(T)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .loader_go   (loader_go),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .input_data  (input_data),
    .input_valid (input_valid),
    .input_start (input_start),
    .input_end   (input_end),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // kind: 0 = input_start, 1 = input_valid, 2 = input_end
  typedef struct { int c; int k; int d; } ev_t;
  ev_t got_q[$];
  ev_t exp_q[$];

  bit         p_go[$];
  bit         p_v[$];
  logic [7:0] p_d[$];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!reset) begin
      if (input_start || input_valid || input_end)
        chk("strobe_exclusive", 32'(input_start) + 32'(input_valid) + 32'(input_end), 32'd1);
      if (input_start) got_q.push_back('{cyc, 0, 0});
      if (input_valid) got_q.push_back('{cyc, 1, int'(input_data)});
      if (input_end)   got_q.push_back('{cyc, 2, 0});
    end
  end

  task automatic plan_new();
    p_go.delete(); p_v.delete(); p_d.delete();
    p_go.push_back(1'b1); p_v.push_back(1'b0); p_d.push_back(8'($urandom));
  endtask

  task automatic plan_idle(input int n);
    for (int i = 0; i < n; i++) begin
      p_go.push_back(1'b0); p_v.push_back(1'b0); p_d.push_back(8'($urandom));
    end
  endtask

  task automatic plan_byte(input int gap, input logic [7:0] d);
    plan_idle(gap - 1);
    p_go.push_back(1'b0); p_v.push_back(1'b1); p_d.push_back(d);
  endtask

  task automatic plan_hdr(input logic [31:0] c, input int gap);
    for (int i = 3; i >= 0; i--) plan_byte(gap, c[8*i +: 8]);
  endtask

  // Reference: header bytes accumulate MSB first; a gap of T cycles since the
  // last accepted byte (or the arm / start cycle) aborts. Payload byte at
  // offset i appears at i+1; end pulse one cycle after the last strobe.
  task automatic model(input int a, output int e_done, output int e_err);
    int hdr = 0;
    int last = 0;
    int i = 1;
    int s, n, fw;
    logic [31:0] cnt = '0;
    exp_q.delete();
    e_done = 0;
    e_err = 0;
    while (hdr < 4) begin
      if (i >= last + T) begin e_err = 1; return; end
      if (i < p_v.size() && p_v[i]) begin
        cnt = {cnt[23:0], p_d[i]};
        hdr++;
        last = i;
      end
      i++;
    end
    if (cnt > (32'd1 << W)) begin e_err = 1; return; end
    s = i;
    exp_q.push_back('{a + s, 0, 0});
    n = int'(cnt) * 4;
    if (n == 0) begin
      exp_q.push_back('{a + s + 1, 2, 0});
      e_done = 1;
      return;
    end
    last = s;
    fw = 0;
    i = s;
    while (1) begin
      if (i >= last + T) begin
        exp_q.push_back('{a + i, 2, 0});
        e_err = 1;
        return;
      end
      if (i < p_v.size() && p_v[i]) begin
        exp_q.push_back('{a + i + 1, 1, int'(p_d[i])});
        fw++;
        last = i;
        if (fw == n) begin
          exp_q.push_back('{a + i + 2, 2, 0});
          e_done = 1;
          return;
        end
      end
      i++;
    end
  endtask

  task automatic run_plan(input string tag);
    int a = 0;
    int ed, ee;
    int last_d = -1;
    got_q.delete();
    for (int k = 0; k < p_v.size(); k++) begin
      @(posedge CLK); #1;
      if (k == 0) a = cyc;
      loader_go = p_go[k];
      rx_valid  = p_v[k];
      rx_data   = p_d[k];
    end
    @(posedge CLK); #1;
    loader_go = 1'b0;
    rx_valid  = 1'b0;
    repeat (T + 6) @(posedge CLK);
    #1;
    model(a, ed, ee);
    chk({tag, ":n_events"}, got_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      chk($sformatf("%s:ev%0d_cycle", tag, j), got_q[j].c - a, exp_q[j].c - a);
      chk($sformatf("%s:ev%0d_kind", tag, j), got_q[j].k, exp_q[j].k);
      if (exp_q[j].k == 1) begin
        chk($sformatf("%s:ev%0d_data", tag, j), got_q[j].d, exp_q[j].d);
        last_d = exp_q[j].d;
      end
    end
    chk({tag, ":done"}, 32'(done), 32'(ed));
    chk({tag, ":error"}, 32'(error), 32'(ee));
    chk({tag, ":busy"}, 32'(busy), 32'd0);
    if (last_d >= 0) chk({tag, ":data_hold"}, 32'(input_data), 32'(last_d));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt, n_extra, g, end_evs;

    // Reset state.
    #1;
    chk("rst_async_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK) reset = 1'b0;
    @(negedge CLK);
    chk("rst_input_data", 32'(input_data), 32'd0);
    chk("rst_input_valid", 32'(input_valid), 32'd0);
    chk("rst_input_start", 32'(input_start), 32'd0);
    chk("rst_input_end", 32'(input_end), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    // Basic 2-word load, go pulses while busy in HDR and DATA.
    plan_new();
    plan_hdr(32'd2, 1);
    for (int i = 1; i <= 8; i++) plan_byte(5, 8'(i * 8'h11));
    p_go[3] = 1'b1;
    p_go[p_go.size() - 3] = 1'b1;
    run_plan("two_words");

    plan_new(); plan_hdr(32'd0, 1); plan_byte(1, 8'h77); run_plan("zero_words");
    plan_new(); plan_hdr(32'd5, 2); plan_byte(1, 8'h01); run_plan("too_big");
    plan_new(); plan_hdr(32'h0100_0000, 1); run_plan("huge_header");

    plan_new(); plan_hdr(32'd4, 1);
    for (int i = 0; i < 16; i++) plan_byte($urandom_range(1, 4), 8'($urandom));
    run_plan("max_words");

    plan_new(); plan_hdr(32'd1, 1); plan_byte(3, 8'hC1); plan_byte(3, 8'hC2);
    run_plan("data_timeout");

    plan_new(); plan_byte(1, 8'h00); plan_byte(2, 8'h00); run_plan("hdr_timeout");

    // First payload byte in the START cycle, back-to-back burst, trailing
    // bytes landing in the last-strobe and END cycles.
    plan_new(); plan_hdr(32'd1, 1);
    plan_byte(1, 8'hA5); plan_byte(1, 8'hB6); plan_byte(1, 8'hC7); plan_byte(1, 8'hD8);
    plan_byte(1, 8'hE9); plan_byte(1, 8'hFA);
    run_plan("skid");

    // Random loads, occasionally oversized or stalled.
    for (int it = 0; it < 14; it++) begin
      plan_new();
      cnt = $urandom_range(0, 5);
      if ($urandom_range(0, 7) == 0) plan_hdr(32'($urandom), $urandom_range(1, 3));
      else plan_hdr(32'(cnt), $urandom_range(1, 3));
      for (int i = 0; i < cnt * 4; i++) begin
        g = ($urandom_range(0, 11) == 0) ? $urandom_range(12, 20) : $urandom_range(1, 6);
        plan_byte(g, 8'($urandom));
      end
      n_extra = $urandom_range(0, 3);
      for (int i = 0; i < n_extra; i++) plan_byte(1, 8'($urandom));
      run_plan($sformatf("rand%0d", it));
    end

    // Asynchronous reset in the middle of DATA.
    plan_new(); plan_hdr(32'd4, 1);
    for (int i = 0; i < 16; i++) plan_byte(2, 8'h5A);
    got_q.delete();
    for (int k = 0; k < 13; k++) begin
      @(posedge CLK); #1;
      loader_go = p_go[k];
      rx_valid  = p_v[k];
      rx_data   = p_d[k];
    end
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_input_data", 32'(input_data), 32'd0);
    chk("mid_rst_input_valid", 32'(input_valid), 32'd0);
    chk("mid_rst_input_end", 32'(input_end), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    loader_go = 1'b0;
    rx_valid  = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) reset = 1'b0;
    repeat (3) @(negedge CLK);
    end_evs = 0;
    foreach (got_q[j]) if (got_q[j].k == 2) end_evs++;
    chk("mid_rst_no_end", 32'(end_evs), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);

    plan_new(); plan_hdr(32'd1, 1);
    for (int i = 0; i < 4; i++) plan_byte(2, 8'($urandom));
    run_plan("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
